// File: rtl/delay_ctrl_pkg.sv
// Shared types and default widths for the delay-line tap controller.
// Contents: state_e (controller FSM states), tap_t / sample_t and the
// default TAP_W / SAMPLE_W / MAX_TAP values.
package delay_ctrl_pkg;

   localparam int unsigned TAP_W_DEF    = 5;
   localparam int unsigned SAMPLE_W_DEF = 13;
   localparam int unsigned MAX_TAP_DEF  = 31;

   typedef logic        [TAP_W_DEF-1:0]    tap_t;
   typedef logic signed [SAMPLE_W_DEF-1:0] sample_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SLEW,
      ST_SETTLE,
      ST_SCAN_SETTLE,
      ST_SCAN_DWELL,
      ST_SCAN_NEXT
   } state_e;

endpackage

// File: rtl/mag_accum.sv
// Accumulates |sample| of a two's-complement input.
// Ports: clk, rst_n (async active-low), clr (synchronous clear, wins over en),
//        en (add |sample| this cycle), sample (signed input), acc (running sum).
module mag_accum #(
   parameter int unsigned SAMPLE_W = 13,
   parameter int unsigned ACC_W    = 17
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                en,
   input  logic [SAMPLE_W-1:0] sample,
   output logic [ACC_W-1:0]    acc
);

   logic [SAMPLE_W-1:0] mag_c;

   // Negating the most negative code wraps to 2^(SAMPLE_W-1), which is the
   // correct magnitude once read as unsigned.
   always_comb begin
      mag_c = sample;
      if (sample[SAMPLE_W-1]) mag_c = SAMPLE_W'(~sample + SAMPLE_W'(1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   acc <= '0;
      else if (clr) acc <= '0;
      else if (en)  acc <= acc + ACC_W'(mag_c);
   end

endmodule

// File: rtl/delay_tap_ctrl.sv
// Tap controller for the variable-tap delay line: glitch-free one-step-per-cycle
// slewing on host command, plus a calibration scan that parks on the tap with
// the largest accumulated |sample|.
// Ports: clk, rst_n; host cmd_valid/cmd_ready/cmd_tap; scan_start; sample
//        (delay-line output); tap (to delay line); busy; done and err pulses;
//        best_tap/best_mag (result of the last scan).
module delay_tap_ctrl
   import delay_ctrl_pkg::*;
#(
   parameter  int unsigned TAP_W      = TAP_W_DEF,
   parameter  int unsigned MAX_TAP    = MAX_TAP_DEF,
   parameter  int unsigned SAMPLE_W   = SAMPLE_W_DEF,
   parameter  int unsigned SETTLE_CYC = 4,
   parameter  int unsigned DWELL_LOG2 = 4,
   localparam int unsigned ACC_W      = SAMPLE_W + DWELL_LOG2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [TAP_W-1:0]    cmd_tap,
   input  logic                scan_start,
   input  logic [SAMPLE_W-1:0] sample,
   output logic [TAP_W-1:0]    tap,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [TAP_W-1:0]    best_tap,
   output logic [ACC_W-1:0]    best_mag
);

   localparam int unsigned DWELL_N = 2 ** DWELL_LOG2;
   localparam int unsigned CNT_MAX = (SETTLE_CYC > DWELL_N) ? SETTLE_CYC : DWELL_N;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

   localparam logic [TAP_W-1:0] MAX_TAP_V   = TAP_W'(MAX_TAP);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'(DWELL_N - 1);

   state_e             state_q,    state_d;
   logic [TAP_W-1:0]   tap_q,      tap_d;
   logic [TAP_W-1:0]   target_q,   target_d;
   logic [CNT_W-1:0]   cnt_q,      cnt_d;
   logic               busy_q,     busy_d;
   logic               done_q,     done_d;
   logic               err_q,      err_d;
   logic               ready_q,    ready_d;
   logic [TAP_W-1:0]   best_tap_q, best_tap_d;
   logic [ACC_W-1:0]   best_mag_q, best_mag_d;

   logic [TAP_W-1:0]   tgt_c;
   logic               acc_clr_c;
   logic               acc_en_c;
   logic [ACC_W-1:0]   acc_c;

   mag_accum #(
      .SAMPLE_W (SAMPLE_W),
      .ACC_W    (ACC_W)
   ) u_mag_accum (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (acc_clr_c),
      .en     (acc_en_c),
      .sample (sample),
      .acc    (acc_c)
   );

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         tap_q      <= '0;
         target_q   <= '0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         ready_q    <= 1'b1;
         best_tap_q <= '0;
         best_mag_q <= '0;
      end else begin
         state_q    <= state_d;
         tap_q      <= tap_d;
         target_q   <= target_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         ready_q    <= ready_d;
         best_tap_q <= best_tap_d;
         best_mag_q <= best_mag_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d    = state_q;
      tap_d      = tap_q;
      target_d   = target_q;
      cnt_d      = cnt_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      ready_d    = ready_q;
      best_tap_d = best_tap_q;
      best_mag_d = best_mag_q;
      acc_clr_c  = 1'b0;
      acc_en_c   = 1'b0;
      tgt_c      = (cmd_tap > MAX_TAP_V) ? MAX_TAP_V : cmd_tap;

      case (state_q)
         ST_IDLE: begin
            if (scan_start) begin
               // Calibration data is unqualified, so jump straight to tap 0.
               state_d    = ST_SCAN_SETTLE;
               tap_d      = '0;
               cnt_d      = '0;
               best_tap_d = '0;
               best_mag_d = '0;
               acc_clr_c  = 1'b1;
               busy_d     = 1'b1;
               ready_d    = 1'b0;
            end else if (cmd_valid && ready_q) begin
               err_d    = (cmd_tap > MAX_TAP_V);
               target_d = tgt_c;
               if (tgt_c == tap_q) begin
                  done_d = 1'b1;
               end else begin
                  // First step is taken on the accept edge.
                  tap_d   = (tgt_c > tap_q) ? tap_q + TAP_W'(1) : tap_q - TAP_W'(1);
                  state_d = ST_SLEW;
                  busy_d  = 1'b1;
                  ready_d = 1'b0;
               end
            end
         end

         ST_SLEW: begin
            if (tap_q == target_q) begin
               state_d = ST_SETTLE;
               cnt_d   = '0;
            end else begin
               tap_d = (target_q > tap_q) ? tap_q + TAP_W'(1) : tap_q - TAP_W'(1);
            end
         end

         ST_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               ready_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_SCAN_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               state_d = ST_SCAN_DWELL;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_SCAN_DWELL: begin
            acc_en_c = 1'b1;
            if (cnt_q == DWELL_LAST) begin
               state_d = ST_SCAN_NEXT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_SCAN_NEXT: begin
            acc_clr_c = 1'b1;
            // Strict compare so a tie keeps the lower tap.
            if (acc_c > best_mag_q) begin
               best_mag_d = acc_c;
               best_tap_d = tap_q;
            end
            cnt_d = '0;
            if (tap_q < MAX_TAP_V) begin
               tap_d   = tap_q + TAP_W'(1);
               state_d = ST_SCAN_SETTLE;
            end else begin
               tap_d   = best_tap_d;
               state_d = ST_SETTLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            ready_d = 1'b1;
         end
      endcase
   end

   assign tap       = tap_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign cmd_ready = ready_q;
   assign best_tap  = best_tap_q;
   assign best_mag  = best_mag_q;

endmodule

// File: doc/delay_tap_ctrl.md
Name: delay_tap_ctrl

Overview:
- Controller for the 32-deep variable-tap delay line (13-bit signed data, 5-bit tap).
- Owns the delay line's tap input and moves it glitch-free, one tap per cycle, on host command.
- Also runs an autonomous calibration scan. The scan sweeps every tap, measures accumulated |sample| at the delay output, and parks on the tap with the largest magnitude.
- Sits between the register/host interface and the delay line.

Parameters:
- TAP_W, 5, tap width.
- MAX_TAP, 31, highest legal tap.
- SAMPLE_W, 13, signed sample width.
- SETTLE_CYC, 4, cycles waited after the final tap change before data is trusted. Must be ≥2 to cover the delay line's output register.
- DWELL_LOG2, 4, log2 of samples accumulated per tap during a scan.
- ACC_W, SAMPLE_W+DWELL_LOG2, accumulator width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  host requests a new tap
- cmd_ready  out  1  controller can accept a command (high only in IDLE)
- cmd_tap  in  TAP_W  requested tap
- scan_start  in  1  start a calibration scan (sampled only in IDLE)
- sample  in  SAMPLE_W  signed delay-line output
- tap  out  TAP_W  tap driven to the delay line
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when a command or scan completes
- err  out  1  one-cycle pulse when cmd_tap > MAX_TAP (clamped)
- best_tap  out  TAP_W  result of the last scan
- best_mag  out  ACC_W  accumulated magnitude at best_tap

Behaviour:
- Reset (async, rst_n=0):
  - tap=0, busy=0, done=0, err=0, cmd_ready=1.
  - best_tap=0, best_mag=0; state=IDLE; all counters 0.
  - Reset mid-slew or mid-scan aborts immediately. No done pulse is issued.
- States: IDLE, SLEW, SETTLE, SCAN_SETTLE, SCAN_DWELL, SCAN_NEXT. All outputs are registered.
- IDLE:
  - Handshake is cmd_valid && cmd_ready.
  - scan_start has priority over cmd_valid in the same cycle. The command is not accepted and stays pending on the host side.
- Command accept (cycle 0):
  - target = min(cmd_tap, MAX_TAP). err pulses in cycle 1 if clamped.
  - If target == tap: done pulses in cycle 1, state stays IDLE, no settle.
  - Otherwise go to SLEW.
- SLEW:
  - tap moves ±1 per cycle toward target. With distance d, tap reaches target at cycle d.
  - Then go to SETTLE.
- SETTLE:
  - Counts SETTLE_CYC cycles.
  - On exit, done=1 for one cycle and IDLE is entered in the same cycle (busy=0, cmd_ready=1).
  - Accept-to-done latency is d+SETTLE_CYC+1 cycles.
- Scan start:
  - tap jumps to 0 directly, with no slew, because the data path is unqualified during calibration.
  - Accumulator is cleared. best_mag=0, best_tap=0.
- SCAN_SETTLE: discard SETTLE_CYC samples.
- SCAN_DWELL:
  - acc += |sample| for 2^DWELL_LOG2 cycles.
  - |−4096| = 4096, so the full unsigned SAMPLE_W range is used with no saturation. ACC_W cannot overflow.
- SCAN_NEXT (one cycle):
  - If acc > best_mag (strict), update best_mag=acc and best_tap=tap. Ties keep the lower tap.
  - Clear acc.
  - If tap < MAX_TAP: tap+1, back to SCAN_SETTLE.
  - Else: tap=best_tap (jump), then SETTLE, then done.
- Scan length: (MAX_TAP+1)·(SETTLE_CYC+2^DWELL_LOG2+1) + SETTLE_CYC + 1 cycles.
- best_tap and best_mag hold until the next scan_start or reset.
- Ignored inputs: scan_start outside IDLE; cmd_valid while cmd_ready=0 (host must hold it).

Decomposition:
- Package delay_ctrl_pkg holds:
  - the state enum;
  - TAP_W, SAMPLE_W, MAX_TAP defaults;
  - the tap_t and sample_t typedefs.
- One sub-module, mag_accum, holds the abs-value plus accumulator with clear/enable. It outputs an ACC_W sum and is reusable by other calibration blocks.
- FSM, counters and tap register stay in delay_tap_ctrl.

Test Plan:
- Reset, then cmd_tap=5 accepted at cycle 0 (SETTLE_CYC=4) -> tap=1,2,3,4,5 at cycles 1..5; done at cycle 10; busy high cycles 1..9; cmd_ready low throughout.
- tap=20, cmd_tap=17 -> tap 19,18,17 at cycles 1..3; done at cycle 8.
- cmd_tap=20 with tap=20 -> done at cycle 1, busy never asserted; then cmd_tap=31 from tap=0 gives a 31-cycle slew.
- Illegal target with MAX_TAP=23 parameterised, cmd_tap=30 -> err pulse at cycle 1; final tap=23.
- Scan with sample = +100 when tap==12 and −4096 when tap==7, otherwise 0 (DWELL 16):
  - best_mag=65536 and best_tap=7;
  - final tap=7; done one cycle after final settle.
  - Repeat with both taps at magnitude 100 -> best_tap=7 (lower tap wins the tie).
- Reset asserted during SCAN_DWELL at tap 9 -> tap=0, busy=0, best_tap=0, best_mag=0 immediately; no done pulse. scan_start and cmd_valid together in IDLE -> scan runs and the command waits.
